// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter: state
// encoding, default bus widths and the saturating-increment helper.
package mem_port_arbiter_pkg;

  localparam int unsigned MEM_ARB_ADDR_W = 32;
  localparam int unsigned MEM_ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_DATA = 2'd1,
    ARB_INST = 2'd2
  } arb_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side and RAM-side signals of the memory port arbiter. The arbiter
// connects through the slave modport; the environment uses master.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ARB_ADDR_W,
  parameter int unsigned DATA_W = MEM_ARB_DATA_W
);
  logic              inst_ren;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_data;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] mem_din;
  logic              stall;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_ack;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout,
           ram_ack, ram_rdata,
    output inst_data, mem_din, stall, ram_req, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout,
           ram_ack, ram_rdata,
    input  inst_data, mem_din, stall, ram_req, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_stat.sv
// Optional saturating statistics counters for the memory port arbiter;
// instantiated by the top only when MEM_ARB_STAT_EN is defined.
module mem_arb_stat
  import mem_port_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        conflict,
  output logic [31:0] stat_stall_cycles,
  output logic [31:0] stat_conflicts
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_stall_cycles <= '0;
      stat_conflicts    <= '0;
    end else begin
      if (stall)    stat_stall_cycles <= sat_inc(stat_stall_cycles);
      if (conflict) stat_conflicts    <= sat_inc(stat_conflicts);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external RAM port between instruction fetch and data access,
// data first, stalling the pipeline until all current requests complete.
// MEM_ARB_STAT_EN adds stall/conflict statistics outputs.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ARB_ADDR_W,
  parameter int unsigned DATA_W = MEM_ARB_DATA_W
)(
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
`ifdef MEM_ARB_STAT_EN
  ,
  output logic [31:0]         stat_stall_cycles,
  output logic [31:0]         stat_conflicts
`endif
);

  arb_state_t        state_q, state_d;
  logic              data_done_q, inst_done_q;
  logic              data_open, inst_open, stall_c;
  logic [DATA_W-1:0] inst_data_q, mem_din_q;
  logic              ram_req_c, ram_we_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [DATA_W-1:0] ram_wdata_c;

  // A request is open until its done flag is set for this core cycle.
  assign data_open = (bus.mem_ren | bus.mem_wen) & ~data_done_q;
  assign inst_open = bus.inst_ren & ~inst_done_q;
  assign stall_c   = data_open | inst_open;

  assign bus.stall     = stall_c;
  assign bus.inst_data = inst_data_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.ram_req   = ram_req_c;
  assign bus.ram_we    = ram_we_c;
  assign bus.ram_addr  = ram_addr_c;
  assign bus.ram_wdata = ram_wdata_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ARB_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (data_open)      state_d = ARB_DATA;
        else if (inst_open) state_d = ARB_INST;
      end
      ARB_DATA: if (bus.ram_ack) state_d = inst_open ? ARB_INST : ARB_IDLE;
      ARB_INST: if (bus.ram_ack) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    ram_req_c   = 1'b0;
    ram_we_c    = 1'b0;
    ram_addr_c  = '0;
    ram_wdata_c = '0;
    case (state_q)
      ARB_DATA: begin
        ram_req_c   = 1'b1;
        ram_we_c    = bus.mem_wen;
        ram_addr_c  = bus.mem_addr;
        ram_wdata_c = bus.mem_dout;
      end
      ARB_INST: begin
        ram_req_c  = 1'b1;
        ram_addr_c = bus.inst_addr;
      end
      default: ;
    endcase
  end

  // Done flags live for one core cycle: they clear whenever the pipeline advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_done_q <= 1'b0;
      inst_done_q <= 1'b0;
      inst_data_q <= '0;
      mem_din_q   <= '0;
    end else begin
      if (!stall_c) begin
        data_done_q <= 1'b0;
        inst_done_q <= 1'b0;
      end else if (bus.ram_ack) begin
        if (state_q == ARB_DATA) data_done_q <= 1'b1;
        if (state_q == ARB_INST) inst_done_q <= 1'b1;
      end
      if (bus.ram_ack && state_q == ARB_DATA && bus.mem_ren && !bus.mem_wen)
        mem_din_q <= bus.ram_rdata;
      if (bus.ram_ack && state_q == ARB_INST)
        inst_data_q <= bus.ram_rdata;
    end
  end

`ifdef MEM_ARB_STAT_EN
  logic conflict_c;
  assign conflict_c = (state_q == ARB_IDLE) & data_open & inst_open;

  mem_arb_stat u_stat (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall_c),
    .conflict          (conflict_c),
    .stat_stall_cycles (stat_stall_cycles),
    .stat_conflicts    (stat_conflicts)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a RAM model pops expected accesses
// from a scoreboard queue; results are checked with immediate assertions.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ram_txn_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARB_STAT_EN
  logic [31:0] stat_stall_cycles, stat_conflicts;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef MEM_ARB_STAT_EN
    ,
    .stat_stall_cycles (stat_stall_cycles),
    .stat_conflicts    (stat_conflicts)
`endif
  );

  ram_txn_t    exp_q[$];
  ram_txn_t    cur;
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned lat = 1;
  int unsigned acc_cnt = 0;
  bit          ram_auto = 1'b0;
  bit          in_acc = 1'b0;

  function automatic logic [31:0] ram_data(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2408_0005;
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RAM model: acks in the lat-th cycle of each request, checks hold stability.
  task automatic ram_step();
    ram_txn_t e;
    if (!ram_auto) return;
    if (bus.ram_req === 1'b1) begin
      if (!in_acc) begin
        in_acc  = 1'b1;
        acc_cnt = 1;
        cur = '{we: bus.ram_we, addr: bus.ram_addr, wdata: bus.ram_wdata};
        if (exp_q.size() == 0) begin
          chk("ram_extra_req", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("ram_we", 32'(bus.ram_we), 32'(e.we));
          chk("ram_addr", bus.ram_addr, e.addr);
          if (e.we) chk("ram_wdata", bus.ram_wdata, e.wdata);
        end
      end else begin
        acc_cnt++;
        chk("ram_hold_addr", bus.ram_addr, cur.addr);
        chk("ram_hold_we", 32'(bus.ram_we), 32'(cur.we));
        chk("ram_hold_wdata", bus.ram_wdata, cur.wdata);
      end
      if (acc_cnt >= lat) begin
        bus.ram_ack   = 1'b1;
        bus.ram_rdata = ram_data(cur.addr);
        in_acc        = 1'b0;
      end else begin
        bus.ram_ack   = 1'b0;
        bus.ram_rdata = 32'hCCCC_CCCC;
      end
    end else begin
      if (in_acc) chk("ram_req_dropped", 32'(bus.ram_req), 32'd1);
      in_acc        = 1'b0;
      bus.ram_ack   = 1'b0;
      bus.ram_rdata = 32'hCCCC_CCCC;
    end
  endtask

  // One core cycle, entered and left at posedge+1.
  task automatic step(output logic st);
    @(negedge clk);
    ram_step();
    #1;
    st = bus.stall;
    @(posedge clk);
    #1;
  endtask

  task automatic run(output int unsigned n);
    logic st;
    bit   freed;
    freed = 1'b0;
    n = 0;
    st = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(st);
      if (st === 1'b0) begin
        freed = 1'b1;
        break;
      end
      n++;
    end
    if (!freed) chk("stall_timeout", 32'(st), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    logic        st;
    logic [31:0] md;
    logic [31:0] a;
`ifdef MEM_ARB_STAT_EN
    logic [31:0] s0, c0;
`endif

    bus.inst_ren  = 1'b1;
    bus.inst_addr = 32'h40;
    bus.mem_ren   = 1'b1;
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = 32'h100;
    bus.mem_dout  = 32'h0;
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h5555_5555;

    // Reset held with requests and a spurious ack active
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_req", 32'(bus.ram_req), 32'd0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst_ram_addr", bus.ram_addr, 32'd0);
    chk("rst_ram_wdata", bus.ram_wdata, 32'd0);
    chk("rst_inst_data", bus.inst_data, 32'd0);
    chk("rst_mem_din", bus.mem_din, 32'd0);
    chk("rst_stall_req", 32'(bus.stall), 32'd1);
    bus.inst_ren = 1'b0;
    bus.mem_ren  = 1'b0;
    bus.ram_ack  = 1'b0;
    #1;
    chk("rst_stall_idle", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ram_auto = 1'b1;
    @(posedge clk);
    #1;

    // Single instruction fetch, L=1
    lat = 1;
    exp_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
    bus.inst_addr = 32'h40;
    bus.inst_ren  = 1'b1;
    run(n);
    chk("single_stall_cycles", n, 32'd2);
    chk("single_inst_data", bus.inst_data, 32'h2408_0005);
    bus.inst_ren = 1'b0;

    // Data and instruction in the same core cycle, L=2
`ifdef MEM_ARB_STAT_EN
    s0 = stat_stall_cycles;
    c0 = stat_conflicts;
`endif
    lat = 2;
    exp_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
    exp_q.push_back('{we: 1'b0, addr: 32'h44, wdata: 32'h0});
    bus.mem_addr  = 32'h100;
    bus.mem_ren   = 1'b1;
    bus.inst_addr = 32'h44;
    bus.inst_ren  = 1'b1;
    run(n);
    chk("conflict_stall_cycles", n, 32'd5);
    chk("conflict_mem_din", bus.mem_din, ram_data(32'h100));
    chk("conflict_inst_data", bus.inst_data, ram_data(32'h44));
    bus.mem_ren  = 1'b0;
    bus.inst_ren = 1'b0;
`ifdef MEM_ARB_STAT_EN
    chk("stat_conflicts", stat_conflicts - c0, 32'd1);
    chk("stat_stall_cycles", stat_stall_cycles - s0, 32'd5);
`endif

    // Write, L=3, must not disturb mem_din
    md  = bus.mem_din;
    lat = 3;
    exp_q.push_back('{we: 1'b1, addr: 32'h200, wdata: 32'hDEAD_BEEF});
    bus.mem_addr = 32'h200;
    bus.mem_dout = 32'hDEAD_BEEF;
    bus.mem_wen  = 1'b1;
    run(n);
    chk("write_stall_cycles", n, 32'd4);
    chk("write_mem_din_kept", bus.mem_din, md);

    // Read and write together behave as a write
    lat = 1;
    exp_q.push_back('{we: 1'b1, addr: 32'h204, wdata: 32'h1234_5678});
    bus.mem_addr = 32'h204;
    bus.mem_dout = 32'h1234_5678;
    bus.mem_ren  = 1'b1;
    bus.mem_wen  = 1'b1;
    run(n);
    chk("rw_stall_cycles", n, 32'd2);
    chk("rw_mem_din_kept", bus.mem_din, md);
    bus.mem_ren = 1'b0;
    bus.mem_wen = 1'b0;

    // Ack while idle with no requests is ignored
    ram_auto      = 1'b0;
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h0BAD_0BAD;
    step(st);
    chk("idle_no_stall", 32'(st), 32'd0);
    step(st);
    chk("idle_ram_req", 32'(bus.ram_req), 32'd0);
    chk("idle_mem_din", bus.mem_din, md);
    chk("idle_inst_data", bus.inst_data, ram_data(32'h44));
    bus.ram_ack = 1'b0;
    ram_auto    = 1'b1;

    // Back-to-back fetches with inst_ren held: 1,1,0 each
    lat = 1;
    bus.inst_ren = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      a = 32'(k * 4);
      exp_q.push_back('{we: 1'b0, addr: a, wdata: 32'h0});
      bus.inst_addr = a;
      run(n);
      chk("b2b_stall_cycles", n, 32'd2);
      chk("b2b_inst_data", bus.inst_data, ram_data(a));
    end
    bus.inst_ren = 1'b0;

    // Reset while the data access waits for its ack
    ram_auto     = 1'b0;
    bus.mem_addr = 32'h300;
    bus.mem_ren  = 1'b1;
    step(st);
    step(st);
    chk("mid_ram_req_before", 32'(bus.ram_req), 32'd1);
    chk("mid_ram_addr_before", bus.ram_addr, 32'h300);
    rst = 1'b0;
    #1;
    chk("mid_ram_req_reset", 32'(bus.ram_req), 32'd0);
    chk("mid_ram_addr_reset", bus.ram_addr, 32'd0);
    bus.mem_ren = 1'b0;
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.ram_ack   = 1'b1;
    bus.ram_rdata = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    bus.ram_ack = 1'b0;
    chk("late_ack_ram_req", 32'(bus.ram_req), 32'd0);
    chk("late_ack_mem_din", bus.mem_din, 32'd0);

    in_acc   = 1'b0;
    ram_auto = 1'b1;
    lat = 2;
    exp_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0});
    bus.mem_ren = 1'b1;
    run(n);
    chk("post_rst_stall_cycles", n, 32'd3);
    chk("post_rst_mem_din", bus.mem_din, ram_data(32'h300));
    bus.mem_ren = 1'b0;

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one external memory port between the instruction-fetch and data-access interfaces of the 5-stage MIPS core. Sits between `mips_core` (`inst_*` / `mem_*` ports) and a single variable-latency RAM. Serialises requests, data before instruction, and drives a stall to the pipeline controller until every request of the current core cycle has completed.

## Interface
Parameters:
- `ADDR_W`, 32: address width on both sides.
- `DATA_W`, 32: data width.

Ports:
- `clk`  in  1  main clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `inst_ren`  in  1  core instruction read request.
- `inst_addr`  in  ADDR_W  instruction address.
- `inst_data`  out  DATA_W  fetched instruction.
- `mem_ren`  in  1  core data read request.
- `mem_wen`  in  1  core data write request.
- `mem_addr`  in  ADDR_W  data address.
- `mem_dout`  in  DATA_W  core write data.
- `mem_din`  out  DATA_W  data returned to the core.
- `stall`  out  1  high while any current core request is unfinished; freezes all pipeline stage enables.
- `ram_req`  out  1  external request.
- `ram_we`  out  1  external write strobe, valid with `ram_req`.
- `ram_addr`  out  ADDR_W  external address.
- `ram_wdata`  out  DATA_W  external write data.
- `ram_ack`  in  1  one-cycle completion pulse; `ram_rdata` valid in the same cycle.
- `ram_rdata`  in  DATA_W  external read data.

## Operation
- FSM states: `IDLE`, `DATA`, `INST`.
- `IDLE`: if a data request (`mem_ren|mem_wen`) is pending and `data_done=0`, go to `DATA`. Otherwise, if `inst_ren` is pending and `inst_done=0`, go to `INST`. Otherwise stay.
- `DATA`: `ram_req=1`. `ram_we=mem_wen`, `ram_addr=mem_addr`, `ram_wdata=mem_dout`, all taken from the core's held signals. On `ram_ack`:
  - set `data_done`;
  - latch `ram_rdata` into the `mem_din` register (reads only);
  - go to `INST` if an instruction request is pending and not done, else `IDLE`.
- `INST`: `ram_req=1`, `ram_we=0`, `ram_addr=inst_addr`. On `ram_ack`: set `inst_done`, latch `inst_data`, go to `IDLE`.
- `mem_ren` and `mem_wen` both high: treated as a write. No read data is latched.
- `stall = (data_pending & ~data_done) | (inst_pending & ~inst_done)`. The term is combinational from the core requests and the done flags.
- Done flags clear in any cycle where `stall=0`, i.e. when the pipeline advances. A new request in the following cycle is therefore serviced afresh.
- Requests must stay stable while `stall=1`. This is guaranteed by the core freezing its stages.
- `ram_req` never drops before `ram_ack`. Address and data are stable for the whole request.

## Timing
- Reset values: state `IDLE`, done flags 0, `inst_data=0`, `mem_din=0`, `ram_req=0`, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`. `stall` follows its equation.
- `ram_req` rises the cycle after the request is first seen in `IDLE`.
- RAM latency `L≥1` cycles after `ram_req`. Single access: `stall` is high for `L+1` cycles and low in the cycle after `ram_ack`; the latched data is valid in that cycle.
- Both requests: `stall` is high for `(L_data+1)+L_inst` cycles with no idle gap between `DATA` and `INST`.
- No request: `stall=0`, zero-cycle overhead.
- Reset mid-access: FSM returns to `IDLE` immediately. An outstanding `ram_ack` arriving after reset is ignored.
- `ram_ack` seen in `IDLE` is ignored.

## Configuration
- `MEM_ARB_STAT_EN` defined adds two 32-bit saturating counters:
  - `stat_stall_cycles` counts cycles with `stall=1`;
  - `stat_conflicts` counts core cycles in which data and instruction requests were both pending at first sight.
  - Both counters reset to 0 and are exposed as outputs `stat_stall_cycles` and `stat_conflicts`, 32 bits each.
- `MEM_ARB_STAT_EN` undefined: the counters and ports are absent. Behaviour is otherwise identical.

## Structure
- A shared package holds the state encoding (`ARB_IDLE=2'd0`, `ARB_DATA=2'd1`, `ARB_INST=2'd2`) and the `ADDR_W`/`DATA_W` defaults, so `define.vh` stays the single source.
- One sub-module, `mem_arb_stat`, contains the optional counters. It is instantiated only under `MEM_ARB_STAT_EN`.

## Test plan
- Reset low with requests active: all outputs at reset values, `ram_req=0`. After release, a single `inst_ren` at `0x0000_0040` with RAM `L=1` returning `0x2408_0005`: `stall` high 2 cycles, then `inst_data=0x2408_0005` with `stall=0`.
- Simultaneous `mem_ren@0x100` and `inst_ren@0x44`, `L=2`: RAM sees the data address first, then `0x44`. `stall` high 5 cycles. Both outputs are correct.
- `mem_wen` at `0x200` with data `0xDEAD_BEEF`: `ram_we=1` with `ram_wdata=0xDEAD_BEEF` stable until ack. `mem_din` unchanged.
- Back-to-back fetches `0x0, 0x4, 0x8`, `L=1`: each gets a fresh access. `stall` pattern is 1,1,0 repeated. No stale data.
- Reset asserted while in `DATA` with ack pending: state `IDLE` at once. A late `ram_ack` is ignored. After release, the next request completes normally.
- With `MEM_ARB_STAT_EN`, run the conflict scenario once: `stat_conflicts=1`, `stat_stall_cycles=5`.
